// File: rtl/muldiv_hilo_ctrl_if.sv
// muldiv_hilo_ctrl_if
//   Bundles the execute-stage request and result signals of the multiply/divide
//   sequencer. The slave modport is the sequencer's view; master is the pipeline's.
//   Requests : i_start, i_flush, i_funct, i_data_a (rs), i_data_b (rt)
//   Results  : o_busy (stall), o_done (FIX pulse), o_hi, o_lo, o_result (MFHI/MFLO mux)
interface muldiv_hilo_ctrl_if #(
    parameter int unsigned BITS_SIZE  = 32,
    parameter int unsigned BITS_FUNCT = 6
);
    logic                  i_start;
    logic                  i_flush;
    logic [BITS_FUNCT-1:0] i_funct;
    logic [BITS_SIZE-1:0]  i_data_a;
    logic [BITS_SIZE-1:0]  i_data_b;
    logic                  o_busy;
    logic                  o_done;
    logic [BITS_SIZE-1:0]  o_hi;
    logic [BITS_SIZE-1:0]  o_lo;
    logic [BITS_SIZE-1:0]  o_result;

    modport slave (
        input  i_start, i_flush, i_funct, i_data_a, i_data_b,
        output o_busy, o_done, o_hi, o_lo, o_result
    );

    modport master (
        output i_start, i_flush, i_funct, i_data_a, i_data_b,
        input  o_busy, o_done, o_hi, o_lo, o_result
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
//   Iterative multiply/divide sequencer owning the MIPS HI/LO pair. Runs a
//   BITS_SIZE-step shift-add multiply or restoring divide on operand magnitudes,
//   then applies sign fixups in a single FIX cycle and writes HI/LO.
//   Build option: define MULDIV_DIV_EN to include the divider; without it
//   DIV/DIVU are accepted as no-ops.
// Ports
//   i_clk      : clock, rising edge
//   i_reset_n  : synchronous active-low reset
//   bus        : muldiv_hilo_ctrl_if.slave (start/flush/funct/operands in;
//                busy/done/hi/lo/result out)
module muldiv_hilo_ctrl #(
    parameter int unsigned BITS_SIZE  = 32,
    parameter int unsigned BITS_FUNCT = 6,
    parameter int unsigned BITS_CNT   = 5
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    muldiv_hilo_ctrl_if.slave   bus
);

    localparam int unsigned W = BITS_SIZE;

    localparam logic [BITS_FUNCT-1:0] FUNCT_MFHI  = BITS_FUNCT'(6'b010000);
    localparam logic [BITS_FUNCT-1:0] FUNCT_MTHI  = BITS_FUNCT'(6'b010001);
    localparam logic [BITS_FUNCT-1:0] FUNCT_MFLO  = BITS_FUNCT'(6'b010010);
    localparam logic [BITS_FUNCT-1:0] FUNCT_MTLO  = BITS_FUNCT'(6'b010011);
    localparam logic [BITS_FUNCT-1:0] FUNCT_MULT  = BITS_FUNCT'(6'b011000);
    localparam logic [BITS_FUNCT-1:0] FUNCT_MULTU = BITS_FUNCT'(6'b011001);
`ifdef MULDIV_DIV_EN
    localparam logic [BITS_FUNCT-1:0] FUNCT_DIV   = BITS_FUNCT'(6'b011010);
    localparam logic [BITS_FUNCT-1:0] FUNCT_DIVU  = BITS_FUNCT'(6'b011011);
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] ST_DIV  = 2'd2;
`endif
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam logic [BITS_CNT-1:0] CNT_LAST = BITS_CNT'(BITS_SIZE - 1);

    logic [1:0]          state_q, state_d;
    logic [BITS_CNT-1:0] cnt_q, cnt_d;
    // MUL: {partial product high, multiplier shifting out}.
    // DIV: {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*W-1:0]      prod_q, prod_d;
    // Multiplicand magnitude (MUL) or divisor magnitude (DIV).
    logic [W-1:0]        opb_q, opb_d;
    logic                neg_res_q, neg_res_d;
    logic [W-1:0]        hi_q, hi_d;
    logic [W-1:0]        lo_q, lo_d;
`ifdef MULDIV_DIV_EN
    logic                neg_rem_q, neg_rem_d;
    logic                op_div_q, op_div_d;
`endif

    // Operand decode and magnitudes
    logic           is_mul, is_signed;
    logic [W-1:0]   mag_a, mag_b;
    logic           sign_a, sign_b;
`ifdef MULDIV_DIV_EN
    logic           is_div;
`endif

    always_comb begin
        is_mul = (bus.i_funct == FUNCT_MULT) || (bus.i_funct == FUNCT_MULTU);
`ifdef MULDIV_DIV_EN
        is_div    = (bus.i_funct == FUNCT_DIV) || (bus.i_funct == FUNCT_DIVU);
        is_signed = (bus.i_funct == FUNCT_MULT) || (bus.i_funct == FUNCT_DIV);
`else
        is_signed = (bus.i_funct == FUNCT_MULT);
`endif
        sign_a = is_signed & bus.i_data_a[W-1];
        sign_b = is_signed & bus.i_data_b[W-1];
        mag_a  = sign_a ? (~bus.i_data_a + 1'b1) : bus.i_data_a;
        mag_b  = sign_b ? (~bus.i_data_b + 1'b1) : bus.i_data_b;
    end

    // One shift-add multiply step.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        mul_next = {mul_sum, prod_q[W-1:1]};
    end

`ifdef MULDIV_DIV_EN
    // One restoring-divide step: shift in the next dividend bit and try the divisor.
    // The trial result fits in W bits whenever it is non-negative, so bit W is the borrow.
    logic [W:0]     div_trial;
    logic [2*W-1:0] div_next;

    always_comb begin
        div_trial = {prod_q[2*W-1:W], prod_q[W-1]} - {1'b0, opb_q};
        if (!div_trial[W]) begin
            div_next = {div_trial[W-1:0], prod_q[W-2:0], 1'b1};
        end else begin
            div_next = {prod_q[2*W-2:0], 1'b0};
        end
    end
`endif

    // Sign fixups applied in FIX
    logic [2*W-1:0] prod_fix;
`ifdef MULDIV_DIV_EN
    logic [W-1:0]   quo_fix, rem_fix;
`endif

    always_comb begin
        prod_fix = neg_res_q ? (~prod_q + 1'b1) : prod_q;
`ifdef MULDIV_DIV_EN
        quo_fix  = neg_res_q ? (~prod_q[W-1:0] + 1'b1) : prod_q[W-1:0];
        rem_fix  = neg_rem_q ? (~prod_q[2*W-1:W] + 1'b1) : prod_q[2*W-1:W];
`endif
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef MULDIV_DIV_EN
        neg_rem_d = neg_rem_q;
        op_div_d  = op_div_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    if (is_mul) begin
                        // Multiplier sits in the low half and is consumed LSB first.
                        prod_d    = {{W{1'b0}}, mag_b};
                        opb_d     = mag_a;
                        neg_res_d = sign_a ^ sign_b;
                        cnt_d     = CNT_LAST;
                        state_d   = ST_MUL;
`ifdef MULDIV_DIV_EN
                        op_div_d  = 1'b0;
                        neg_rem_d = 1'b0;
`endif
                    end
`ifdef MULDIV_DIV_EN
                    else if (is_div) begin
                        prod_d    = {{W{1'b0}}, mag_a};
                        opb_d     = mag_b;
                        neg_res_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                        op_div_d  = 1'b1;
                        cnt_d     = CNT_LAST;
                        state_d   = ST_DIV;
                    end
`endif
                    else if (bus.i_funct == FUNCT_MTHI) begin
                        hi_d = bus.i_data_a;
                    end else if (bus.i_funct == FUNCT_MTLO) begin
                        lo_d = bus.i_data_a;
                    end
                end
            end
            ST_MUL: begin
                prod_d = mul_next;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef MULDIV_DIV_EN
            ST_DIV: begin
                prod_d = div_next;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            ST_FIX: begin
`ifdef MULDIV_DIV_EN
                if (op_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end
`else
                hi_d = prod_fix[2*W-1:W];
                lo_d = prod_fix[W-1:0];
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush beats everything the FSM wanted this cycle: no accept, no MT*
        // write, no FIX write-back.
        if (bus.i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
            op_div_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= neg_rem_d;
            op_div_q  <= op_div_d;
`endif
        end
    end

    // Outputs
    always_comb begin
        bus.o_busy = (state_q != ST_IDLE);
        bus.o_done = (state_q == ST_FIX) && !bus.i_flush;
        bus.o_hi   = hi_q;
        bus.o_lo   = lo_q;
        if (bus.i_funct == FUNCT_MFHI) begin
            bus.o_result = hi_q;
        end else if (bus.i_funct == FUNCT_MFLO) begin
            bus.o_result = lo_q;
        end else begin
            bus.o_result = '0;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl
//   Directed bench for muldiv_hilo_ctrl: HI/LO moves, signed/unsigned multiply,
//   divide (or the no-op DIV path when MULDIV_DIV_EN is undefined), flush, reset.
module tb_muldiv_hilo_ctrl;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_NOP   = 6'b111111;

    logic clk;
    logic reset_n;
    int   check_cnt;
    int   err_cnt;

    muldiv_hilo_ctrl_if #(.BITS_SIZE(32), .BITS_FUNCT(6)) bus ();

    muldiv_hilo_ctrl #(
        .BITS_SIZE  (32),
        .BITS_FUNCT (6),
        .BITS_CNT   (5)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Single-cycle accept of an MT*/no-op style request; returns at the negedge of cycle 1.
    task automatic issue(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_funct  = funct;
        bus.i_data_a = a;
        bus.i_data_b = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_funct = F_NOP;
        @(negedge clk);
    endtask

    // Accept an op and follow it until busy drops (bounded). Leaves i_funct=MFHI so
    // o_result in cycle 1 reports the pre-op HI.
    task automatic run_op(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt, output int done_cyc, output logic [31:0] res_c1);
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_funct  = funct;
        bus.i_data_a = a;
        bus.i_data_b = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_funct = F_MFHI;
        busy_cnt = 0;
        done_cyc = 0;
        res_c1   = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) res_c1 = bus.o_result;
            if (bus.o_done) done_cyc = k;
            if (bus.o_busy) busy_cnt++;
            else break;
        end
    endtask

    int          bc, dc, done_seen;
    logic [31:0] r1;

    initial begin
        check_cnt    = 0;
        err_cnt      = 0;
        reset_n      = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_flush  = 1'b0;
        bus.i_funct  = F_MFHI;
        bus.i_data_a = '0;
        bus.i_data_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hi", bus.o_hi, 32'h0);
        check_eq("rst_lo", bus.o_lo, 32'h0);
        check_eq("rst_busy", {31'b0, bus.o_busy}, 32'h0);
        check_eq("rst_done", {31'b0, bus.o_done}, 32'h0);
        check_eq("rst_result", bus.o_result, 32'h0);
        reset_n = 1'b1;

        // MTHI / MTLO and the MF* read mux
        issue(F_MTHI, 32'h12345678, 32'h0);
        check_eq("mthi_hi", bus.o_hi, 32'h12345678);
        check_eq("mthi_busy", {31'b0, bus.o_busy}, 32'h0);
        issue(F_MTLO, 32'h9ABCDEF0, 32'h0);
        check_eq("mtlo_lo", bus.o_lo, 32'h9ABCDEF0);
        check_eq("mtlo_hi_kept", bus.o_hi, 32'h12345678);
        bus.i_funct = F_MFHI;
        #1 check_eq("mfhi_result", bus.o_result, 32'h12345678);
        bus.i_funct = F_MFLO;
        #1 check_eq("mflo_result", bus.o_result, 32'h9ABCDEF0);
        bus.i_funct = F_MULT;
        #1 check_eq("other_result", bus.o_result, 32'h0);

        // -2 x 3 signed, then unsigned
        run_op(F_MULT, 32'hFFFFFFFE, 32'h00000003, bc, dc, r1);
        check_eq("mult_busy_cycles", bc, 33);
        check_eq("mult_done_cycle", dc, 33);
        check_eq("mult_mfhi_busy", r1, 32'h12345678);
        check_eq("mult_hi", bus.o_hi, 32'hFFFFFFFF);
        check_eq("mult_lo", bus.o_lo, 32'hFFFFFFFA);
        run_op(F_MULTU, 32'hFFFFFFFE, 32'h00000003, bc, dc, r1);
        check_eq("multu_busy_cycles", bc, 33);
        check_eq("multu_done_cycle", dc, 33);
        check_eq("multu_mfhi_busy", r1, 32'hFFFFFFFF);
        check_eq("multu_hi", bus.o_hi, 32'h00000002);
        check_eq("multu_lo", bus.o_lo, 32'hFFFFFFFA);

`ifdef MULDIV_DIV_EN
        run_op(F_DIV, 32'hFFFFFFF9, 32'h00000002, bc, dc, r1);
        check_eq("div_busy_cycles", bc, 33);
        check_eq("div_done_cycle", dc, 33);
        check_eq("div_lo", bus.o_lo, 32'hFFFFFFFD);
        check_eq("div_hi", bus.o_hi, 32'hFFFFFFFF);
        run_op(F_DIVU, 32'h00000064, 32'h00000000, bc, dc, r1);
        check_eq("divu0_lo", bus.o_lo, 32'hFFFFFFFF);
        check_eq("divu0_hi", bus.o_hi, 32'h00000064);
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, bc, dc, r1);
        check_eq("divovf_lo", bus.o_lo, 32'h80000000);
        check_eq("divovf_hi", bus.o_hi, 32'h00000000);
`else
        run_op(F_DIVU, 32'd10, 32'd3, bc, dc, r1);
        check_eq("divu_nodiv_busy", bc, 0);
        check_eq("divu_nodiv_done", dc, 0);
        check_eq("divu_nodiv_hi", bus.o_hi, 32'h00000002);
        check_eq("divu_nodiv_lo", bus.o_lo, 32'hFFFFFFFA);
`endif

        run_op(F_MULTU, 32'd7, 32'd6, bc, dc, r1);
        check_eq("multu76_lo", bus.o_lo, 32'h0000002A);
        check_eq("multu76_hi", bus.o_hi, 32'h00000000);

        // Flush at cycle 10 of a MULT while a second start (MTHI) is held in cycles 1..5
        done_seen = 0;
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_funct  = F_MULT;
        bus.i_data_a = 32'h00010000;
        bus.i_data_b = 32'h00010000;
        @(posedge clk);
        #1;
        bus.i_funct  = F_MTHI;
        bus.i_data_a = 32'hDEADBEEF;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.o_done) done_seen++;
            if (k == 6) bus.i_start = 1'b0;
            if (k == 10) begin
                check_eq("flush_busy_c10", {31'b0, bus.o_busy}, 32'h1);
                bus.i_flush = 1'b1;
            end
        end
        @(posedge clk);
        #1 bus.i_flush = 1'b0;
        bus.i_funct = F_NOP;
        @(negedge clk);
        check_eq("flush_busy_c11", {31'b0, bus.o_busy}, 32'h0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.o_done || bus.o_busy) done_seen++;
        end
        check_eq("flush_no_done", done_seen, 0);
        check_eq("flush_hi_kept", bus.o_hi, 32'h00000000);
        check_eq("flush_lo_kept", bus.o_lo, 32'h0000002A);

        // Flush in IDLE suppresses an MTLO
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_flush  = 1'b1;
        bus.i_funct  = F_MTLO;
        bus.i_data_a = 32'h55555555;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_funct = F_NOP;
        @(negedge clk);
        check_eq("idle_flush_lo", bus.o_lo, 32'h0000002A);
        check_eq("idle_flush_busy", {31'b0, bus.o_busy}, 32'h0);

        // Reset at cycle 20 of a long op
        @(negedge clk);
        bus.i_start = 1'b1;
`ifdef MULDIV_DIV_EN
        bus.i_funct = F_DIVU;
`else
        bus.i_funct = F_MULTU;
`endif
        bus.i_data_a = 32'd100;
        bus.i_data_b = 32'd7;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_funct = F_NOP;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 20) begin
                check_eq("rstmid_busy_c20", {31'b0, bus.o_busy}, 32'h1);
                reset_n = 1'b0;
            end
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_eq("rstmid_busy", {31'b0, bus.o_busy}, 32'h0);
        check_eq("rstmid_hi", bus.o_hi, 32'h0);
        check_eq("rstmid_lo", bus.o_lo, 32'h0);
        repeat (40) begin
            @(negedge clk);
            if (bus.o_busy || bus.o_done) done_seen++;
        end
        check_eq("rstmid_quiet", done_seen, 0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_ctrl.md
# muldiv_hilo_ctrl

Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS execute stage. It sits beside the ALU, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO function codes from decode/execute, and runs a 32-step shift-add or restoring-divide loop. While the loop runs it drives a stall to the pipeline. MFHI/MFLO read back results through a registered-source mux.

## Interface
- BITS_SIZE, 32, data width; the iteration count equals BITS_SIZE
- BITS_FUNCT, 6, function-code width
- BITS_CNT, 5, iteration counter width (log2 BITS_SIZE)

- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  synchronous, active-low reset (one clock, synchronous reset, active low)
- i_start  in  1  op valid this cycle; sampled only in IDLE
- i_flush  in  1  abort any op in flight
- i_funct  in  BITS_FUNCT  MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
- i_data_a  in  BITS_SIZE  rs: multiplicand or dividend; MTHI/MTLO source
- i_data_b  in  BITS_SIZE  rt: multiplier or divisor
- o_busy  out  1  high whenever state != IDLE; drives pipeline stall
- o_done  out  1  one-cycle pulse in the FIX cycle
- o_hi  out  BITS_SIZE  HI register
- o_lo  out  BITS_SIZE  LO register
- o_result  out  BITS_SIZE  combinational: HI when i_funct=MFHI, LO when MFLO, else 0

## Operation
- States: IDLE, MUL, DIV, FIX.
- In IDLE with i_start=1:
  - MULT/MULTU → MUL.
  - DIV/DIVU → DIV.
  - MTHI/MTLO write HI/LO at the clock edge and stay in IDLE (no busy).
  - MFHI/MFLO do nothing sequential.
  - Other codes are ignored.
- On accept, latch these into internal registers:
  - operand magnitudes (two's-complement absolute value for signed ops, raw value for unsigned ops);
  - the result-sign flag: sign_a XOR sign_b, signed ops only;
  - the remainder-sign flag: sign_a, DIV only.
- MUL: 32 iterations of shift-add into a 2×BITS_SIZE accumulator.
- DIV: 32 iterations of restoring division, producing quotient and remainder magnitudes.
- FIX (1 cycle):
  - Apply sign corrections: negate the 64-bit product, or negate the quotient and/or remainder.
  - MUL results: HI = product[63:32], LO = product[31:0].
  - DIV results: HI = remainder, LO = quotient.
  - Write HI/LO at the end of FIX, assert o_done, return to IDLE.
- Divide by zero: no special path.
  - DIVU yields LO=FFFFFFFF, HI=i_data_a.
  - DIV yields the same raw magnitudes with sign fixups applied; the bench checks DIVU only.
- Overflow case 80000000 / FFFFFFFF (DIV): LO=80000000, HI=0.
- i_start while busy is ignored; upstream holds the instruction via o_busy.
- i_flush in MUL/DIV/FIX: go to IDLE next cycle, HI/LO unchanged, no o_done.
- i_flush in IDLE blocks the same-cycle accept and suppresses an MTHI/MTLO write in that cycle.
- MFHI/MFLO issued while busy: o_result shows the pre-op HI/LO; the stall prevents consumption.
- Priority per cycle: reset > flush > FSM.

## Timing
- Reset (i_reset_n=0 at an edge): state=IDLE, HI=0, LO=0, counter=0, o_busy=0, o_done=0, o_result=0.
- Reset mid-op discards the op.
- Cycle 0: accept edge. Cycles 1..32: MUL/DIV, with the counter going 31→0. Cycle 33: FIX with o_done=1.
- New HI/LO are visible from cycle 34.
- o_busy is high in cycles 1..33, i.e. 33 cycles.
- The earliest next accept is the edge ending cycle 34, when IDLE is re-entered.
- MTHI/MTLO: value visible on o_hi/o_lo one cycle after the accept edge.
- o_result has zero latency from i_funct and the HI/LO registers.

## Configuration
- MULDIV_DIV_EN
  - Defined: DIV/DIVU are implemented as above.
  - Undefined: no divider datapath and no DIV state. DIV/DIVU in IDLE are accepted as no-ops: no busy, HI/LO unchanged, no o_done.
- MUL, MT*, MF* are unaffected by the macro.

## Test plan
- Reset then idle: o_hi=o_lo=0, o_busy=0. MTHI 12345678, then MTLO 9ABCDEF0 → next cycle o_hi=12345678, o_lo=9ABCDEF0; MFHI → o_result=12345678.
- MULT FFFFFFFE × 00000003 (−2×3) → o_busy high 33 cycles, o_done in cycle 33, HI=FFFFFFFF, LO=FFFFFFFA. MULTU with the same operands → HI=00000002, LO=FFFFFFFA.
- DIV FFFFFFF9 / 00000002 (−7/2) → LO=FFFFFFFD, HI=FFFFFFFF. DIVU 00000064 / 00000000 → LO=FFFFFFFF, HI=00000064. DIV 80000000 / FFFFFFFF → LO=80000000, HI=0.
- MULT 00010000 × 00010000 with i_flush at cycle 10 → o_busy drops cycle 11, no o_done, HI/LO keep prior values. A second i_start held during busy is not accepted.
- i_reset_n low at cycle 20 of a DIVU → next cycle IDLE, HI=LO=0, o_busy=0.
- Build without MULDIV_DIV_EN: DIVU 10/3 → o_busy stays 0, HI/LO unchanged. MULTU 7×6 still gives LO=0000002A.
